ones_comp_deser: RTL and testbench

//   Receive end of the bit-serial one's-complement link. Takes the complemented

---
 rtl/ones_comp_pkg.sv | 12 +
 rtl/ones_comp_deser.sv | 75 +++++++
 tb/tb_ones_comp_deser.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ones_comp_pkg.sv
// ones_comp_pkg: state encodings shared by both ends of the one's-complement serial link.
package ones_comp_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RECV = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        RECV = ST_RECV
    } state_e;

endpackage

// File: rtl/ones_comp_deser.sv
// ones_comp_deser: re-inverts the complemented serial stream and assembles LSB-first words
// behind a one-word valid/ready holding register.
module ones_comp_deser
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             last_d;
    logic [WIDTH-1:0] word_d;

    // last_d marks the cycle bit WIDTH-1 lands; word_d is the finished word including it
    always_comb begin
        last_d = in_valid && !in_sof && state_q == RECV && cnt_q == CW'(WIDTH - 1);
        word_d = shift_q;
        word_d[WIDTH-1] = ~in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    shift_q <= {{(WIDTH-1){1'b0}}, ~in_data};
                    cnt_q   <= CW'(1);
                    state_q <= RECV;
                end else if (state_q == RECV) begin
                    shift_q[cnt_q] <= ~in_data;
                    cnt_q   <= last_d ? '0 : cnt_q + CW'(1);
                    state_q <= last_d ? IDLE : RECV;
                end
            end
            // a full holding register only takes the new word if it is drained this same cycle
            if (last_d) begin
                if (!out_valid_q || out_ready) begin
                    out_data_q  <= word_d;
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ones_comp_deser.sv
// tb_ones_comp_deser: table-driven frames plus hand-written stall, restart, overrun and reset sequences.
module tb_ones_comp_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_data = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       overrun;

    int vec_cnt = 0;
    int err_cnt = 0;
    int ov_cnt;

    typedef struct packed {
        logic [7:0] line;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    ones_comp_deser #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v, input logic s, input logic d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        logic [7:0] ln;
        tbl[0] = '{line: 8'h5A, exp: 8'hA5};
        tbl[1] = '{line: 8'hFF, exp: 8'h00};
        tbl[2] = '{line: 8'h00, exp: 8'hFF};
        tbl[3] = '{line: 8'hC3, exp: 8'h3C};
        tbl[4] = '{line: 8'h0F, exp: 8'hF0};
        tbl[5] = '{line: 8'h96, exp: 8'h69};
        tbl[6] = '{line: 8'h81, exp: 8'h7E};

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_data", 32'(out_data), 0);
        chk("reset overrun", 32'(overrun), 0);
        rst = 1'b1;
        send_bit(0, 0, 0);

        // back-to-back frames with ready held high
        for (int k = 0; k < 7; k++) begin
            ln = tbl[k].line;
            for (int i = 0; i < 7; i++) send_bit(1, i == 0, ln[i]);
            chk($sformatf("tbl%0d pre-last valid", k), 32'(out_valid), 0);
            send_bit(1, 0, ln[7]);
            chk($sformatf("tbl%0d valid", k), 32'(out_valid), 1);
            chk($sformatf("tbl%0d data", k), 32'(out_data), 32'(tbl[k].exp));
            chk($sformatf("tbl%0d overrun", k), 32'(overrun), 0);
        end
        send_bit(0, 0, 0);
        chk("drain valid", 32'(out_valid), 0);

        // 3-cycle line stall after bit 4
        ln = 8'h5A;
        for (int i = 0; i < 5; i++) send_bit(1, i == 0, ln[i]);
        repeat (3) begin
            send_bit(0, 0, 1);
            chk("stall valid", 32'(out_valid), 0);
        end
        send_bit(1, 0, ln[5]);
        send_bit(1, 0, ln[6]);
        chk("stall pre-last valid", 32'(out_valid), 0);
        send_bit(1, 0, ln[7]);
        chk("stall valid", 32'(out_valid), 1);
        chk("stall data", 32'(out_data), 32'h A5);
        send_bit(0, 0, 0);

        // restart at bit 5, then eight ones
        for (int i = 0; i < 5; i++) send_bit(1, i == 0, ln[i]);
        for (int i = 0; i < 7; i++) begin
            send_bit(1, i == 0, 1);
            chk("restart no word", 32'(out_valid), 0);
        end
        send_bit(1, 0, 1);
        chk("restart valid", 32'(out_valid), 1);
        chk("restart data", 32'(out_data), 32'h00);
        send_bit(0, 0, 0);
        chk("restart drained", 32'(out_valid), 0);

        // overrun: ready low, two frames
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1, i == 0, ln[i]);
        chk("ovr first data", 32'(out_data), 32'hA5);
        ln = 8'hC3;
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1, i == 0, ln[i]);
            ov_cnt += int'(overrun);
        end
        chk("ovr pulse at completion", 32'(overrun), 1);
        chk("ovr held data", 32'(out_data), 32'hA5);
        send_bit(0, 0, 0);
        ov_cnt += int'(overrun);
        chk("ovr pulse count", 32'(ov_cnt), 1);
        chk("ovr held valid", 32'(out_valid), 1);
        chk("ovr held data 2", 32'(out_data), 32'hA5);

        // ready in the completion cycle: swap without a bubble
        for (int i = 0; i < 7; i++) begin
            send_bit(1, i == 0, ln[i]);
            chk("swap held valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        send_bit(1, 0, ln[7]);
        out_ready = 1'b0;
        chk("swap valid", 32'(out_valid), 1);
        chk("swap data", 32'(out_data), 32'h3C);
        chk("swap overrun", 32'(overrun), 0);
        send_bit(0, 0, 0);
        chk("swap data held", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        send_bit(0, 0, 0);
        chk("swap drained", 32'(out_valid), 0);

        // async reset mid-frame with a word held
        out_ready = 1'b0;
        ln = 8'h96;
        for (int i = 0; i < 8; i++) send_bit(1, i == 0, ln[i]);
        chk("pre-reset data", 32'(out_data), 32'h69);
        ln = 8'h5A;
        for (int i = 0; i < 4; i++) send_bit(1, i == 0, ln[i]);
        #2 rst = 1'b0;
        #1;
        chk("async rst valid", 32'(out_valid), 0);
        chk("async rst data", 32'(out_data), 0);
        chk("async rst overrun", 32'(overrun), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1, 0, 1);
        chk("idle ignores non-sof", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) send_bit(1, i == 0, ln[i]);
        chk("post-reset valid", 32'(out_valid), 1);
        chk("post-reset data", 32'(out_data), 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
